// File: rtl/pwm_compare_deadtime_16bits_pkg.sv
// Shared types and widths for the compare/dead-time PWM stage.
// The leg state encoding and the gate-polarity helper live here so multi-leg variants can reuse them.
`ifndef DEADTIME_WIDTH
`define DEADTIME_WIDTH 10
`endif
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package pwm_compare_deadtime_16bits_pkg;

    localparam int PWMCOUNT_W = `PWMCOUNT_WIDTH;
    localparam int DEADTIME_W = `DEADTIME_WIDTH;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DT   = 2'd1,
        H_ON = 2'd2,
        L_ON = 2'd3
    } dt_state_e;

    typedef enum logic {
        POL_ACTIVE_HIGH = 1'b0,
        POL_ACTIVE_LOW  = 1'b1
    } out_pol_e;

    // Maps an internal "gate on" bit to the pin level for the selected driver polarity.
    function automatic logic apply_pol(input logic gate_on, input out_pol_e pol);
        return gate_on ^ (pol == POL_ACTIVE_LOW);
    endfunction

endpackage

// File: rtl/pwm_compare_deadtime_16bits_deadtime_leg.sv
// One complementary gate pair: turns a PWM reference into high/low gate commands
// separated by a programmable dead time, with restart on reference edges inside the gap.
module pwm_compare_deadtime_16bits_deadtime_leg
    import pwm_compare_deadtime_16bits_pkg::*;
#(
    parameter int DT_W = DEADTIME_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ref_i,
    input  logic [DT_W-1:0] deadtime_i,
    input  logic            enable_i,
    output logic            gate_h_o,
    output logic            gate_l_o,
    output logic            dt_active_o
);

    dt_state_e       state_q;
    logic [DT_W-1:0] cnt_q;
    logic            ref_prev_q;
    logic            gate_h_q;
    logic            gate_l_q;
    logic            dt_active_q;

    // Leg FSM; gate outputs are registered alongside the state so they never disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            ref_prev_q  <= 1'b0;
            gate_h_q    <= 1'b0;
            gate_l_q    <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            ref_prev_q  <= ref_i;
            gate_h_q    <= 1'b0;
            gate_l_q    <= 1'b0;
            dt_active_q <= 1'b0;
            if (!enable_i) begin
                state_q <= OFF;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    OFF: begin
                        state_q     <= DT;
                        cnt_q       <= deadtime_i;
                        dt_active_q <= 1'b1;
                    end
                    H_ON: begin
                        if (!ref_i) begin
                            state_q     <= DT;
                            cnt_q       <= deadtime_i;
                            dt_active_q <= 1'b1;
                        end else begin
                            gate_h_q <= 1'b1;
                        end
                    end
                    L_ON: begin
                        if (ref_i) begin
                            state_q     <= DT;
                            cnt_q       <= deadtime_i;
                            dt_active_q <= 1'b1;
                        end else begin
                            gate_l_q <= 1'b1;
                        end
                    end
                    DT: begin
                        // A reference edge inside the gap restarts it, so the gate that finally
                        // turns on always matches the latest reference and no runt pulse escapes.
                        if (ref_i != ref_prev_q) begin
                            cnt_q       <= deadtime_i;
                            dt_active_q <= 1'b1;
                        end else if (cnt_q == '0) begin
                            if (ref_i) begin
                                state_q  <= H_ON;
                                gate_h_q <= 1'b1;
                            end else begin
                                state_q  <= L_ON;
                                gate_l_q <= 1'b1;
                            end
                        end else begin
                            cnt_q       <= cnt_q - DT_W'(1);
                            dt_active_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= OFF;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign gate_h_o    = gate_h_q;
    assign gate_l_o    = gate_l_q;
    assign dt_active_o = dt_active_q;

endmodule

// File: rtl/pwm_compare_deadtime_16bits.sv
// Carrier/compare PWM stage with shadowed compare and dead time, driving one
// complementary gate pair through a dead-time leg.
module pwm_compare_deadtime_16bits
    import pwm_compare_deadtime_16bits_pkg::*;
#(
    parameter int CNT_W = PWMCOUNT_W,
    parameter int DT_W  = DEADTIME_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] carrier,
    input  logic             maskevent,
    input  logic [CNT_W-1:0] compare,
    input  logic [DT_W-1:0]  deadtime,
    input  logic             pwm_onoff,
    input  logic             out_pol,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             dt_active
);

    logic [CNT_W-1:0] compare_sh_q;
    logic [CNT_W-1:0] compare_sh_d;
    logic [DT_W-1:0]  deadtime_sh_q;
    logic [DT_W-1:0]  deadtime_sh_d;
    logic             ref_q;
    logic             ref_d;
    logic             shadow_load_s;
    logic             gate_h_s;
    logic             gate_l_s;

    // Shadow next-state and compare; the leg sees deadtime_sh_d so a load on the same edge wins.
    always_comb begin
        shadow_load_s = maskevent | ~pwm_onoff;
        if (shadow_load_s) begin
            compare_sh_d  = compare;
            deadtime_sh_d = deadtime;
        end else begin
            compare_sh_d  = compare_sh_q;
            deadtime_sh_d = deadtime_sh_q;
        end
        ref_d = (carrier < compare_sh_q);
    end

    // Shadow registers and the registered PWM reference.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare_sh_q  <= '0;
            deadtime_sh_q <= '0;
            ref_q         <= 1'b0;
        end else begin
            compare_sh_q  <= compare_sh_d;
            deadtime_sh_q <= deadtime_sh_d;
            ref_q         <= ref_d;
        end
    end

    pwm_compare_deadtime_16bits_deadtime_leg #(
        .DT_W (DT_W)
    ) u_leg (
        .clk         (clk),
        .reset       (reset),
        .ref_i       (ref_q),
        .deadtime_i  (deadtime_sh_d),
        .enable_i    (pwm_onoff),
        .gate_h_o    (gate_h_s),
        .gate_l_o    (gate_l_s),
        .dt_active_o (dt_active)
    );

    assign pwm_h = apply_pol(gate_h_s, out_pol_e'(out_pol));
    assign pwm_l = apply_pol(gate_l_s, out_pol_e'(out_pol));

endmodule

// File: tb/tb_pwm_compare_deadtime_16bits.sv
// Directed bench for pwm_compare_deadtime_16bits: fixed constant-carrier steps plus
// triangle-carrier periods, with hand-computed cycle counts and gate levels.
module tb_pwm_compare_deadtime_16bits;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] carrier;
    logic        maskevent;
    logic [15:0] compare;
    logic [9:0]  deadtime;
    logic        pwm_onoff;
    logic        out_pol;
    logic        pwm_h;
    logic        pwm_l;
    logic        dt_active;

    int n_tests = 0;
    int n_fail  = 0;
    int dt_run  = 0;

    always #5 clk = ~clk;

    pwm_compare_deadtime_16bits dut (
        .clk       (clk),
        .reset     (reset),
        .carrier   (carrier),
        .maskevent (maskevent),
        .compare   (compare),
        .deadtime  (deadtime),
        .pwm_onoff (pwm_onoff),
        .out_pol   (out_pol),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l),
        .dt_active (dt_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] tri_val(input int p);
        if (p < 50) return 16'(2 * p);
        else return 16'(200 - 2 * p);
    endfunction

    // One 100-cycle triangle period (0,2,..,100,..,2); maskevent on the first cycle.
    task automatic tri_period(input bit meas, input int eh, input int el, input int ed,
                              input bit mid_en, input logic [15:0] mid_cmp, input string tag);
        int ch = 0;
        int cl = 0;
        int cd = 0;
        for (int p = 0; p < 100; p++) begin
            nxt();
            if (pwm_h === 1'b1) ch++;
            if (pwm_l === 1'b1) cl++;
            if (dt_active === 1'b1) begin
                cd++;
                dt_run++;
            end else if (dt_run > 0) begin
                chk({tag, "_dt_run_len"}, dt_run, 6);
                dt_run = 0;
            end
            carrier   = tri_val(p);
            maskevent = (p == 0);
            if (mid_en && p == 50) compare = mid_cmp;
        end
        if (meas) begin
            chk({tag, "_h_cycles"}, ch, eh);
            chk({tag, "_l_cycles"}, cl, el);
            chk({tag, "_dt_cycles"}, cd, ed);
        end
    endtask

    always @(negedge clk) begin
        if (!$isunknown({pwm_h, pwm_l, out_pol})) begin
            n_tests++;
            assert (!(((pwm_h ^ out_pol) == 1'b1) && ((pwm_l ^ out_pol) == 1'b1))) else begin
                n_fail++;
                $error("FAIL overlap: pwm_h=%b pwm_l=%b out_pol=%b, both gates active", pwm_h, pwm_l, out_pol);
            end
        end
    end

    initial begin
        int ch;
        int cd;
        reset = 1'b1; pwm_onoff = 1'b0; out_pol = 1'b0; maskevent = 1'b0;
        carrier = 16'd10; compare = 16'd40; deadtime = 10'd5;

        // Reset state, both polarities
        repeat (3) nxt();
        chk("reset_h", pwm_h, 1'b0);
        chk("reset_l", pwm_l, 1'b0);
        chk("reset_dt", dt_active, 1'b0);
        out_pol = 1'b1;
        #1;
        chk("reset_pol_h", pwm_h, 1'b1);
        chk("reset_pol_l", pwm_l, 1'b1);
        out_pol = 1'b0;
        reset = 1'b0;
        repeat (4) nxt();
        chk("off_h", pwm_h, 1'b0);
        chk("off_dt", dt_active, 1'b0);

        // Enable with ref=1: 6 cycles dead time, then high side
        pwm_onoff = 1'b1;
        nxt();
        chk("on_dt_first", dt_active, 1'b1);
        chk("on_h_first", pwm_h, 1'b0);
        repeat (5) nxt();
        chk("on_dt_last", dt_active, 1'b1);
        chk("on_h_last", pwm_h, 1'b0);
        nxt();
        chk("on_h", pwm_h, 1'b1);
        chk("on_dt_end", dt_active, 1'b0);
        chk("on_l", pwm_l, 1'b0);

        // Carrier crossing: 1 clk ref latency, 6 cycles gap, then low side
        carrier = 16'd50;
        nxt();
        chk("fall_lat_h", pwm_h, 1'b1);
        nxt();
        chk("fall_dt_h", pwm_h, 1'b0);
        chk("fall_dt", dt_active, 1'b1);
        repeat (5) nxt();
        chk("fall_dt_last", dt_active, 1'b1);
        chk("fall_l_wait", pwm_l, 1'b0);
        nxt();
        chk("fall_l", pwm_l, 1'b1);
        chk("fall_dt_end", dt_active, 1'b0);

        // Triangle carrier, compare 40 then 70 written mid-period
        tri_period(1'b0, 0, 0, 0, 1'b0, 16'd0, "tri_warm");
        tri_period(1'b1, 33, 55, 12, 1'b0, 16'd0, "tri_c40");
        tri_period(1'b1, 33, 55, 12, 1'b1, 16'd70, "tri_c70_pending");
        tri_period(1'b1, 63, 25, 12, 1'b0, 16'd0, "tri_c70");

        // Compare extremes: no dead-time toggling once settled
        compare = 16'd0;
        tri_period(1'b0, 0, 0, 0, 1'b0, 16'd0, "tri_c0_settle");
        tri_period(1'b1, 0, 100, 0, 1'b0, 16'd0, "tri_c0");
        compare = 16'hFFFF;
        tri_period(1'b0, 0, 0, 0, 1'b0, 16'd0, "tri_cmax_settle");
        tri_period(1'b1, 100, 0, 0, 1'b0, 16'd0, "tri_cmax");

        // Dead time 20 with an 8-cycle reference pulse: restart, no runt on the high side
        compare = 16'd50; deadtime = 10'd20; carrier = 16'd100; maskevent = 1'b1;
        nxt();
        maskevent = 1'b0;
        repeat (29) nxt();
        chk("t4_pre_l", pwm_l, 1'b1);
        chk("t4_pre_dt", dt_active, 1'b0);
        carrier = 16'd0;
        ch = 0;
        cd = 0;
        for (int i = 1; i <= 40; i++) begin
            nxt();
            if (pwm_h === 1'b1) ch++;
            if (dt_active === 1'b1) cd++;
            if (i == 1) chk("t4_l_before", pwm_l, 1'b1);
            if (i == 30) chk("t4_l_still_off", pwm_l, 1'b0);
            if (i == 31) chk("t4_l_back", pwm_l, 1'b1);
            carrier = (i < 8) ? 16'd0 : 16'd100;
        end
        chk("t4_h_cycles", ch, 0);
        chk("t4_dt_cycles", cd, 29);

        // pwm_onoff toggles
        carrier = 16'd0;
        repeat (30) nxt();
        chk("t5_h_on", pwm_h, 1'b1);
        pwm_onoff = 1'b0;
        nxt();
        chk("t5_off_h", pwm_h, 1'b0);
        chk("t5_off_l", pwm_l, 1'b0);
        chk("t5_off_dt", dt_active, 1'b0);
        deadtime = 10'd3;
        repeat (3) nxt();
        pwm_onoff = 1'b1;
        nxt();
        chk("t5_dt_first", dt_active, 1'b1);
        chk("t5_h_first", pwm_h, 1'b0);
        repeat (3) nxt();
        chk("t5_dt_last", dt_active, 1'b1);
        chk("t5_h_last", pwm_h, 1'b0);
        nxt();
        chk("t5_h_on_again", pwm_h, 1'b1);
        chk("t5_dt_end", dt_active, 1'b0);

        // Maskevent on the same edge as the dead-time load uses the new value (7, not 3)
        carrier = 16'd100;
        nxt();
        deadtime = 10'd7;
        maskevent = 1'b1;
        nxt();
        maskevent = 1'b0;
        chk("byp_dt_first", dt_active, 1'b1);
        repeat (7) nxt();
        chk("byp_dt_last", dt_active, 1'b1);
        chk("byp_l_wait", pwm_l, 1'b0);
        nxt();
        chk("byp_l_on", pwm_l, 1'b1);
        chk("byp_dt_end", dt_active, 1'b0);

        // Active-low drivers, then reset in the middle of a dead time
        carrier = 16'd0;
        repeat (12) nxt();
        chk("t6_h_on", pwm_h, 1'b1);
        out_pol = 1'b1;
        #1;
        chk("t6_pol_h", pwm_h, 1'b0);
        chk("t6_pol_l", pwm_l, 1'b1);
        carrier = 16'd100;
        nxt();
        chk("t6_lat_h", pwm_h, 1'b0);
        nxt();
        chk("t6_dt_h", pwm_h, 1'b1);
        chk("t6_dt_l", pwm_l, 1'b1);
        chk("t6_dt", dt_active, 1'b1);
        reset = 1'b1;
        nxt();
        chk("t6_rst_h", pwm_h, 1'b1);
        chk("t6_rst_l", pwm_l, 1'b1);
        chk("t6_rst_dt", dt_active, 1'b0);
        reset = 1'b0;
        nxt();
        chk("post_rst_dt", dt_active, 1'b1);
        nxt();
        chk("post_rst_l", pwm_l, 1'b0);
        chk("post_rst_dt_end", dt_active, 1'b0);
        repeat (2) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
